// File: rtl/serial_adder_if.sv
// Operand/result bundle for the serial add/subtract sequencer.
// The master issues start/mode/a/b; the slave (the sequencer) returns
// busy/done and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder slice reused for every bit,
// LSB first, one bit per clock, with a start/busy/done handshake.

// Gate-level half adder; two of these plus an OR form the bit-slice.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one result bit produced per clock, WIDTH clocks total
// DONE  | one-cycle done pulse; result already registered
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic [CW-1:0]    cnt;

    logic load;
    logic last;
    logic busy_c;
    logic done_c;

    logic s1;
    logic c1;
    logic s_bit;
    logic c2;
    logic co;

    // The shared bit-slice: two half adders, OR of their carries.
    half_adder ha0 (.x(sa[0]), .y(sb[0]), .s(s1),    .c(c1));
    half_adder ha1 (.x(s1),    .y(carry), .s(s_bit), .c(c2));
    assign co = c1 | c2;

    // New bit enters at the MSB so after WIDTH shifts the LSB sits at bit 0.
    assign res_nxt = {s_bit, res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; outputs depend on state only.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry flip-flop, bit counter, partial result.
    // Subtract is a + ~b + 1, so ~b is stored and the carry starts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            sa    <= bus.a;
            sb    <= bus.mode ? ~bus.b : bus.b;
            res   <= '0;
            carry <= bus.mode;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            res   <= res_nxt;
            carry <= co;
            cnt   <= cnt + CW'(1);
        end
    end

    // Visible result: updated only on the final RUN edge so partial sums never show.
    // On that edge carry holds the carry into the MSB, so ovf = carry_in ^ carry_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last) begin
            sum_r  <= res_nxt;
            cout_r <= co;
            ovf_r  <= carry ^ co;
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes the expected
// result and done cycle for each accepted operation; a monitor pops and
// compares whenever done is seen, and checks the result holds otherwise.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           busy_len = 0;
    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;
    logic         held_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic m, input int dcyc);
        exp_t   e;
        longint ua, ub, full, sa, sb, ex, lim;
        ua   = longint'(a);
        ub   = longint'(b);
        lim  = longint'(1) << (W - 1);
        full = m ? (ua + ((longint'(1) << W) - 1 - ub) + 1) : (ua + ub);
        sa   = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb   = b[W-1] ? ub - (longint'(1) << W) : ub;
        ex   = m ? sa - sb : sa + sb;
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ex > lim - 1) || (ex < -lim);
        e.cyc  = dcyc;
        return e;
    endfunction

    // Cycle count and reset bookkeeping: a reset edge discards pending results.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            q.delete();
            held_sum  = '0;
            held_cout = 1'b0;
            held_ovf  = 1'b0;
            busy_len  = 0;
        end
    end

    // Monitor: compare on done, otherwise the result must hold its last value.
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy) busy_len++;
        if (bus.done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: done high with nothing pending (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("sum", bus.sum, e.sum);
                chk("cout", bus.cout, e.cout);
                chk("ovf", bus.ovf, e.ovf);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_len", busy_len, W);
                held_sum  = e.sum;
                held_cout = e.cout;
                held_ovf  = e.ovf;
            end
            busy_len = 0;
        end else begin
            chk("hold_sum", bus.sum, held_sum);
            chk("hold_flags", {bus.cout, bus.ovf}, {held_cout, held_ovf});
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        bus.a     = a;
        bus.b     = b;
        bus.mode  = m;
        bus.start = 1'b1;
        q.push_back(model(a, b, m, cyc + 1 + W));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (W + 1) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_sum"}, bus.sum, 0);
        chk({tag, "_cout"}, bus.cout, 0);
        chk({tag, "_ovf"}, bus.ovf, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_zero("reset");
        @(posedge clk); #1;

        run_op(8'h5A, 8'h3C, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'h10, 8'h20, 1'b1);
        run_op(8'h80, 8'h01, 1'b1);

        // Starts and operand changes during RUN and DONE must be ignored.
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        q.push_back(model(8'h01, 8'h02, 1'b0, cyc + 1 + W));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (W - 4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_after_ignored", {bus.busy, bus.done}, 2'b00);
        @(posedge clk); #1;

        // Reset in the middle of RUN aborts with no done pulse.
        run_op(8'h5A, 8'h3C, 1'b0);
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_zero("abort");
        repeat (W + 4) @(posedge clk);
        #1;
        run_op(8'h05, 8'h06, 1'b0);

        // Start held high: a new random operation every W+2 cycles.
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.mode  = 1'($urandom);
        bus.start = 1'b1;
        q.push_back(model(bus.a, bus.b, bus.mode, cyc + 1 + W));
        for (int i = 1; i < 200; i++) begin
            @(posedge clk); #1;
            bus.a    = W'($urandom);
            bus.b    = W'($urandom);
            bus.mode = 1'($urandom);
            q.push_back(model(bus.a, bus.b, bus.mode, cyc + (W + 2) + W));
            repeat (W + 1) @(posedge clk);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;

        for (int i = 0; i < 4 * W; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that time-shares one 1-bit full adder across all bits of a WIDTH-bit add/subtract, one bit per clock, LSB first, with a start/busy/done handshake.
- The full adder is two gate-level half adders plus an OR for carry. It sits inside this block with a carry flip-flop and operand shift registers.
- Used where area matters more than latency: a parallel ripple adder is replaced by one bit-slice plus this controller.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); latched with operands
- a  input  WIDTH  operand A; latched on accepted start
- b  input  WIDTH  operand B; latched on accepted start
- busy  output  1  high while RUN
- done  output  1  one-cycle pulse in DONE state
- sum  output  WIDTH  result; holds last completed value
- cout  output  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  output  1  signed overflow of the last completed operation

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0. Carry FF, bit counter and shift registers cleared.
- Reset wins over every other input in the same cycle. Reset mid-RUN aborts the operation: no done pulse, and sum/cout/ovf are zeroed, not the partial result.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0: latch a into shift register SA.
  - Latch b into SB, or ~b when mode=1.
  - Carry FF = mode (carry-in 1 for subtract); counter = 0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Bit-slice computes s = SA[0]^SB[0]^c and co = majority(SA[0], SB[0], c).
  - s shifts into the MSB of the internal result shift register; SA and SB shift right; c <= co; counter++.
  - When counter reaches WIDTH-1 at an edge (i.e. the WIDTH-th RUN edge, E_WIDTH), go to DONE.
  - On that same edge, copy the full result to sum, co to cout, and (carry into MSB) XOR co to ovf.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge.
- busy=1 from after E0 through E_WIDTH, i.e. WIDTH cycles. done is high between E_WIDTH and E_WIDTH+1.
- Latency: start accepted to done high = WIDTH+1 edges; next start can be accepted at edge E_WIDTH+2.
- sum/cout/ovf change only on the RUN->DONE transition and on reset. They never show partial values while busy.
- start while RUN or DONE is ignored (not queued). Changes on a, b or mode after E0 have no effect on the current operation.
- start held high continuously: a new operation is accepted each time the block is in IDLE, every WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH. ovf follows two's-complement rules for both add and subtract. cout is a raw carry, not inverted for borrow.
- Counter width: $clog2(WIDTH). No combinational path from inputs to outputs.

Test Plan:
- Add, WIDTH=8: mode=0, a=8'h5A, b=8'h3C, pulse start -> busy for 8 cycles, done pulse 9 edges after start; sum=8'h96, cout=0, ovf=1.
- Wrap: mode=0, a=8'hFF, b=8'h01 -> sum=8'h00, cout=1, ovf=0. Then a=8'h00, b=8'h00 -> sum=8'h00, cout=0, ovf=0.
- Subtract: mode=1, a=8'h10, b=8'h20 -> sum=8'hF0, cout=0, ovf=0. Then a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Ignored start and operand changes: start at cycle 0 with a=8'h01, b=8'h02. Pulse start and change a/b to 8'hFF at cycles 3 and 9 (DONE) -> exactly one done pulse; sum=8'h03; block back in IDLE.
- Reset mid-op: after a prior result sum=8'h96, start a new add, assert reset in cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, and no done pulse. A fresh 8'h05+8'h06 then yields 8'h0B.
- Back-to-back: start held high, random a/b/mode for 200 operations -> done every 10 cycles; every result matches the reference model (sum, cout, ovf).
